// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill engine feeding the 80x60 framebuffer write port.
//
// The MCU loads two corners and a colour through config writes, then issues
// START. The engine streams one framebuffer write per clock in raster order
// over the clamped, normalised rectangle, then pulses DONE for one cycle.
//
// Ports:
//   CLK       system clock
//   RESET_N   synchronous active-low reset
//   CFG_WE    config write strobe (one cycle per write)
//   CFG_SEL   register select: 0 X0, 1 Y0, 2 X1, 3 Y1, 4 COLOR, 5 START, 6 ABORT, 7 reserved
//   CFG_DATA  config write data
//   BUSY      high whenever the engine is not idle
//   DONE      one-cycle pulse after a fill completes normally
//   FB_WA     framebuffer address {Y, X}
//   FB_WD     pixel colour (RRRGGGBB)
//   FB_WE     framebuffer write enable
module vga_rect_fill #(
    parameter int unsigned H_PIX = 80,
    parameter int unsigned V_PIX = 60,
    parameter int unsigned X_W   = 7,
    parameter int unsigned Y_W   = 6
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 CFG_WE,
    input  logic [2:0]           CFG_SEL,
    input  logic [7:0]           CFG_DATA,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [Y_W+X_W-1:0]   FB_WA,
    output logic [7:0]           FB_WD,
    output logic                 FB_WE
);

    localparam logic [2:0] SelX0    = 3'd0;
    localparam logic [2:0] SelY0    = 3'd1;
    localparam logic [2:0] SelX1    = 3'd2;
    localparam logic [2:0] SelY1    = 3'd3;
    localparam logic [2:0] SelColor = 3'd4;
    localparam logic [2:0] SelStart = 3'd5;
    localparam logic [2:0] SelAbort = 3'd6;

    // Largest legal coordinates, in the width of the config registers.
    localparam logic [7:0] XLim = 8'(H_PIX - 1);
    localparam logic [7:0] YLim = 8'(V_PIX - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Config registers hold the raw 8-bit values so START can clamp them.
    logic [7:0] x0_q, x0_d;
    logic [7:0] y0_q, y0_d;
    logic [7:0] x1_q, x1_d;
    logic [7:0] y1_q, y1_d;
    logic [7:0] color_q, color_d;

    // Normalised bounds and the current raster position.
    logic [X_W-1:0] xmin_q, xmin_d;
    logic [X_W-1:0] xmax_q, xmax_d;
    logic [Y_W-1:0] ymin_q, ymin_d;
    logic [Y_W-1:0] ymax_q, ymax_d;
    logic [X_W-1:0] cx_q, cx_d;
    logic [Y_W-1:0] cy_q, cy_d;

    // Clamped corner coordinates, only consumed when START is accepted.
    logic [X_W-1:0] x0_c, x1_c;
    logic [Y_W-1:0] y0_c, y1_c;

    logic abort_req;
    logic at_row_end;
    logic at_last;

    always_comb begin
        x0_c = (x0_q > XLim) ? XLim[X_W-1:0] : x0_q[X_W-1:0];
        x1_c = (x1_q > XLim) ? XLim[X_W-1:0] : x1_q[X_W-1:0];
        y0_c = (y0_q > YLim) ? YLim[Y_W-1:0] : y0_q[Y_W-1:0];
        y1_c = (y1_q > YLim) ? YLim[Y_W-1:0] : y1_q[Y_W-1:0];
    end

    assign abort_req  = CFG_WE && (CFG_SEL == SelAbort);
    assign at_row_end = (cx_q == xmax_q);
    assign at_last    = at_row_end && (cy_q == ymax_q);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        color_d = color_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        cx_d    = cx_q;
        cy_d    = cy_q;

        unique case (state_q)
            StIdle: begin
                if (CFG_WE) begin
                    case (CFG_SEL)
                        SelX0:    x0_d    = CFG_DATA;
                        SelY0:    y0_d    = CFG_DATA;
                        SelX1:    x1_d    = CFG_DATA;
                        SelY1:    y1_d    = CFG_DATA;
                        SelColor: color_d = CFG_DATA;
                        SelStart: begin
                            xmin_d  = (x0_c < x1_c) ? x0_c : x1_c;
                            xmax_d  = (x0_c < x1_c) ? x1_c : x0_c;
                            ymin_d  = (y0_c < y1_c) ? y0_c : y1_c;
                            ymax_d  = (y0_c < y1_c) ? y1_c : y0_c;
                            cx_d    = (x0_c < x1_c) ? x0_c : x1_c;
                            cy_d    = (y0_c < y1_c) ? y0_c : y1_c;
                            state_d = StFill;
                        end
                        // ABORT is a no-op in idle; select 7 is reserved.
                        default: ;
                    endcase
                end
            end
            StFill: begin
                if (at_row_end) begin
                    cx_d = xmin_q;
                    // Never step past the last row; the position is idle after the fill.
                    if (!at_last) begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
                if (at_last) begin
                    state_d = StDone;
                end
                // The write presented this cycle still lands; abort only stops the next.
                if (abort_req) begin
                    state_d = StIdle;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are decoded from the state and registers only.
    always_comb begin
        BUSY  = 1'b0;
        DONE  = 1'b0;
        FB_WE = 1'b0;
        FB_WA = '0;
        FB_WD = '0;
        unique case (state_q)
            StIdle: ;
            StFill: begin
                BUSY  = 1'b1;
                FB_WE = 1'b1;
                FB_WA = {cy_q, cx_q};
                FB_WD = color_q;
            end
            StDone: begin
                BUSY = 1'b1;
                DONE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= StIdle;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            color_q <= color_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
        end
    end

endmodule
